// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants: S-box table, rcon table, round/word count helpers
package aes_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_GEN} ks_state_t;

  // Byte b of the S-box sits at bits [2047-8b -: 8].
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [2047:0] sh;
    sh = SBOX_TBL << {b, 3'b000};
    return sh[2047:2040];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic int nr_of(input int key_bits);
    return (key_bits == 256) ? 14 : 10;
  endfunction

  function automatic int nw_of(input int key_bits);
    return 4 * (nr_of(key_bits) + 1);
  endfunction

endpackage

// File: rtl/aes_subword.sv
// rtl/aes_subword.sv - combinational AES SubWord (four parallel S-box lookups)
module aes_subword
  import aes_pkg::*;
(
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);

  assign word_out = {sbox(word_in[31:24]), sbox(word_in[23:16]),
                     sbox(word_in[15:8]),  sbox(word_in[7:0])};

endmodule

// File: rtl/aes_key_sched.sv
// rtl/aes_key_sched.sv - AES-128/256 key expansion, one word per cycle, registered round-key reads
// Optional AES_KEY_SCHED_DEC_EN adds rk_dec for reverse (decryption order) round-key reads.
module aes_key_sched
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [KEY_BITS-1:0] key_in,
  output logic                busy,
  output logic                done,
  output logic                keys_ok,
  input  logic                rk_req,
  input  logic [3:0]          rk_idx,
`ifdef AES_KEY_SCHED_DEC_EN
  input  logic                rk_dec,
`endif
  output logic [127:0]        rk_out,
  output logic                rk_valid
);

  if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_key_sched: KEY_BITS must be 128 or 256");
  end

  localparam int NK = KEY_BITS / 32;
  localparam int NR = nr_of(KEY_BITS);
  localparam int NW = nw_of(KEY_BITS);
  localparam int LK = $clog2(NK);

  ks_state_t             state_q, state_d;
  logic [5:0]            cnt_q, cnt_d;
  logic [KEY_BITS-1:0]   key_q, key_d;
  logic [31:0]           w_q [NW];
  logic [31:0]           w_d [NW];
  logic                  fin_q, fin_d;
  logic                  done_q, done_d;
  logic                  keys_ok_q, keys_ok_d;
  logic [127:0]          rk_out_q, rk_out_d;
  logic                  rk_valid_q, rk_valid_d;

  logic [31:0] prev_w, far_w, sub_in, sub_out, t_w;
  logic        is_rot, is_sub;

  aes_subword u_subword (
    .word_in  (sub_in),
    .word_out (sub_out)
  );

  // Recurrence operands for the word at index cnt_q.
  always_comb begin
    prev_w = w_q[cnt_q - 6'd1];
    far_w  = w_q[cnt_q - 6'(NK)];
    is_rot = (cnt_q[LK-1:0] == '0);
    is_sub = (NK == 8) && (cnt_q[2:0] == 3'd4);
    sub_in = is_rot ? {prev_w[23:0], prev_w[31:24]} : prev_w;
    if (is_rot) begin
      t_w = sub_out ^ {rcon(4'(cnt_q >> LK)), 24'h0};
    end else if (is_sub) begin
      t_w = sub_out;
    end else begin
      t_w = prev_w;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    key_d     = key_q;
    w_d       = w_q;
    fin_d     = 1'b0;
    done_d    = fin_q;
    keys_ok_d = keys_ok_q | fin_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_LOAD;
          key_d     = key_in;
          keys_ok_d = 1'b0;
        end
      end
      ST_LOAD: begin
        for (int j = 0; j < NK; j++) begin
          w_d[j] = key_q[KEY_BITS-1-32*j -: 32];
        end
        cnt_d   = 6'(NK);
        state_d = ST_GEN;
      end
      ST_GEN: begin
        w_d[cnt_q] = far_w ^ t_w;
        cnt_d      = cnt_q + 6'd1;
        if (cnt_q == 6'(NW - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = 6'd0;
          fin_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reads see keys_ok_q/w_q before this edge, so a same-cycle start cannot disturb them.
  logic [3:0] rd_idx;
  logic [5:0] rd_base;
  always_comb begin
`ifdef AES_KEY_SCHED_DEC_EN
    rd_idx = rk_dec ? (4'(NR) - rk_idx) : rk_idx;
`else
    rd_idx = rk_idx;
`endif
    rd_base    = {rd_idx, 2'b00};
    rk_valid_d = rk_req & keys_ok_q;
    rk_out_d   = rk_out_q;
    if (rk_req && keys_ok_q) begin
      if (rk_idx > 4'(NR)) begin
        rk_out_d = '0;
      end else begin
        rk_out_d = {w_q[rd_base], w_q[rd_base + 6'd1], w_q[rd_base + 6'd2], w_q[rd_base + 6'd3]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 6'd0;
      fin_q      <= 1'b0;
      done_q     <= 1'b0;
      keys_ok_q  <= 1'b0;
      rk_out_q   <= '0;
      rk_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fin_q      <= fin_d;
      done_q     <= done_d;
      keys_ok_q  <= keys_ok_d;
      rk_out_q   <= rk_out_d;
      rk_valid_q <= rk_valid_d;
    end
  end

  // Key and word storage survive reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      key_q <= key_d;
      w_q   <= w_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign keys_ok  = keys_ok_q;
  assign rk_out   = rk_out_q;
  assign rk_valid = rk_valid_q;

endmodule

// File: tb/tb_aes_key_sched.sv
// tb/tb_aes_key_sched.sv - randomized self-checking bench for aes_key_sched (128 and 256 instances)
module tb_aes_key_sched;

  localparam logic [127:0] KEY128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
`ifdef AES_KEY_SCHED_DEC_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic [1:0]   start, rk_req, busy, done, keys_ok, rk_valid;
  logic [3:0]   rk_idx [2];
  logic [127:0] rk_out [2];
  logic [127:0] key128;
  logic [255:0] key256;
`ifdef AES_KEY_SCHED_DEC_EN
  logic [1:0]   rk_dec;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  aes_key_sched #(.KEY_BITS(128)) dut128 (
    .clk(clk), .rst(rst), .start(start[0]), .key_in(key128),
    .busy(busy[0]), .done(done[0]), .keys_ok(keys_ok[0]),
    .rk_req(rk_req[0]), .rk_idx(rk_idx[0]),
`ifdef AES_KEY_SCHED_DEC_EN
    .rk_dec(rk_dec[0]),
`endif
    .rk_out(rk_out[0]), .rk_valid(rk_valid[0])
  );

  aes_key_sched #(.KEY_BITS(256)) dut256 (
    .clk(clk), .rst(rst), .start(start[1]), .key_in(key256),
    .busy(busy[1]), .done(done[1]), .keys_ok(keys_ok[1]),
    .rk_req(rk_req[1]), .rk_idx(rk_idx[1]),
`ifdef AES_KEY_SCHED_DEC_EN
    .rk_dec(rk_dec[1]),
`endif
    .rk_out(rk_out[1]), .rk_valid(rk_valid[1])
  );

  int n_checks = 0;
  int n_pass = 0;
  logic [7:0]   sb_tab [256];
  logic [127:0] mrk [2][15];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference S-box from GF(2^8) inversion plus the affine map.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] inv = 8'h01;
    if (x == 8'h00) inv = 8'h00;
    else for (int k = 0; k < 254; k++) inv = gmul(inv, x);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {sb_tab[v[31:24]], sb_tab[v[23:16]], sb_tab[v[15:8]], sb_tab[v[7:0]]};
  endfunction

  task automatic model_expand(input int w, input logic [255:0] key);
    int nk = w ? 8 : 4;
    int nw = w ? 60 : 44;
    logic [31:0] ws [60];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int j = 0; j < nk; j++) ws[j] = key[32*(nk-1-j) +: 32];
    for (int i = nk; i < nw; i++) begin
      t = ws[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
      end else if (nk == 8 && i % 8 == 4) begin
        t = subw(t);
      end
      ws[i] = ws[i-nk] ^ t;
    end
    for (int r = 0; r < 15; r++) begin
      mrk[w][r] = '0;
      if (4*r + 3 < nw) mrk[w][r] = {ws[4*r], ws[4*r+1], ws[4*r+2], ws[4*r+3]};
    end
  endtask

  // Holds a read of idx 1 throughout; pulse2/rst_at select a mid-run restart or reset (0 = none).
  task automatic expand(input int w, input logic [255:0] key, input int pulse2, input int rst_at,
                        output int lat, output bit pre_v, output logic [127:0] pre_o,
                        output bit saw_v, output bit kok);
    int n = 0;
    if (w == 1) key256 = key; else key128 = key[127:0];
    start[w] = 1'b1; rk_req[w] = 1'b1; rk_idx[w] = 4'd1;
    @(negedge clk);
    start[w] = 1'b0;
    pre_v = rk_valid[w]; pre_o = rk_out[w];
    saw_v = 1'b0; kok = 1'b0; lat = -1;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (rst) begin rst = 1'b0; break; end
      if (rk_valid[w]) saw_v = 1'b1;
      if (done[w]) begin lat = n; kok = keys_ok[w]; break; end
      start[w] = (n == pulse2 - 1);
      if (n == rst_at) rst = 1'b1;
    end
    start[w] = 1'b0; rk_req[w] = 1'b0;
  endtask

  task automatic read1(input int w, input int idx, output bit v, output logic [127:0] o);
    rk_req[w] = 1'b1; rk_idx[w] = 4'(idx);
    @(negedge clk);
    v = rk_valid[w]; o = rk_out[w];
    rk_req[w] = 1'b0;
  endtask

  task automatic read_seq(input int w, input int cnt, input bit dec);
    int nr = w ? 14 : 10;
    int idx;
    logic [127:0] exp;
`ifdef AES_KEY_SCHED_DEC_EN
    rk_dec[w] = dec;
`endif
    for (int k = 0; k < cnt; k++) begin
      idx = $urandom_range(0, nr + 1);
      rk_req[w] = 1'b1; rk_idx[w] = 4'(idx);
      @(negedge clk);
      exp = (idx > nr) ? '0 : mrk[w][dec ? nr - idx : idx];
      check($sformatf("seq%0d_valid[%0d]", w, idx), 128'(rk_valid[w]), 128'(1));
      check($sformatf("seq%0d_out[%0d]", w, idx), rk_out[w], exp);
    end
    rk_req[w] = 1'b0;
`ifdef AES_KEY_SCHED_DEC_EN
    rk_dec[w] = 1'b0;
`endif
  endtask

  initial begin
    int lat;
    bit pv, sv, kok, v;
    logic [127:0] po, o;
    logic [255:0] rkey;

    for (int i = 0; i < 256; i++) sb_tab[i] = sbox_ref(8'(i));
    rst = 1'b1; start = '0; rk_req = '0; rk_idx[0] = '0; rk_idx[1] = '0;
    key128 = '0; key256 = '0;
`ifdef AES_KEY_SCHED_DEC_EN
    rk_dec = '0;
`endif
    repeat (3) @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      check($sformatf("rst_busy%0d", w), 128'(busy[w]), 128'(0));
      check($sformatf("rst_done%0d", w), 128'(done[w]), 128'(0));
      check($sformatf("rst_keys_ok%0d", w), 128'(keys_ok[w]), 128'(0));
      check($sformatf("rst_valid%0d", w), 128'(rk_valid[w]), 128'(0));
      check($sformatf("rst_out%0d", w), rk_out[w], '0);
    end
    rst = 1'b0;

    read1(0, 1, v, o);
    check("noschedule_valid", 128'(v), 128'(0));
    check("noschedule_out", o, '0);

    expand(0, {128'h0, KEY128}, 0, 0, lat, pv, po, sv, kok);
    check("fips128_latency", 128'(lat), 128'(42));
    check("fips128_keys_ok", 128'(kok), 128'(1));
    check("gen_read_valid", 128'(sv), 128'(0));
    @(negedge clk);
    check("done_one_cycle", 128'(done[0]), 128'(0));
    check("idle_busy", 128'(busy[0]), 128'(0));
    read1(0, 1, v, o);
    check("fips128_idx1", o, 128'ha0fafe1788542cb123a339392a6c7605);
    read1(0, 10, v, o);
    check("fips128_idx10", o, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    read1(0, 11, v, o);
    check("idx11_valid", 128'(v), 128'(1));
    check("idx11_out", o, '0);
    model_expand(0, {128'h0, KEY128});
    read_seq(0, 12, 1'b0);

    expand(0, {128'h0, KEY128}, 5, 0, lat, pv, po, sv, kok);
    check("prestart_read_valid", 128'(pv), 128'(1));
    check("prestart_read_out", po, 128'ha0fafe1788542cb123a339392a6c7605);
    check("restart_ignored_latency", 128'(lat), 128'(42));
    read1(0, 10, v, o);
    check("restart_ignored_idx10", o, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    expand(0, {128'h0, KEY128}, 0, 20, lat, pv, po, sv, kok);
    check("abort_no_done", 128'(lat), 128'(-1));
    read1(0, 1, v, o);
    check("abort_read_valid", 128'(v), 128'(0));
    check("abort_keys_ok", 128'(keys_ok[0]), 128'(0));
    check("abort_busy", 128'(busy[0]), 128'(0));
    expand(0, {128'h0, KEY128}, 0, 0, lat, pv, po, sv, kok);
    check("rerun_latency", 128'(lat), 128'(42));
    read1(0, 1, v, o);
    check("rerun_idx1", o, 128'ha0fafe1788542cb123a339392a6c7605);

`ifdef AES_KEY_SCHED_DEC_EN
    rk_dec[0] = 1'b1;
    read1(0, 0, v, o);
    rk_dec[0] = 1'b0;
    check("dec_idx0", o, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
`endif

    expand(1, KEY256, 0, 0, lat, pv, po, sv, kok);
    check("fips256_latency", 128'(lat), 128'(54));
    check("fips256_keys_ok", 128'(kok), 128'(1));
    read1(1, 14, v, o);
    check("fips256_idx14", o, 128'hfe4890d1e6188d0b046df344706c631e);
    read1(1, 15, v, o);
    check("idx15_out", o, '0);
    model_expand(1, KEY256);
    read_seq(1, 16, DEC_EN);

    for (int r = 0; r < 3; r++) begin
      for (int w = 0; w < 2; w++) begin
        for (int k = 0; k < 8; k++) rkey[32*k +: 32] = $urandom;
        if (w == 0) rkey[255:128] = '0;
        model_expand(w, rkey);
        expand(w, rkey, 0, 0, lat, pv, po, sv, kok);
        check($sformatf("rand%0d_latency", w), 128'(lat), 128'(w ? 54 : 42));
        read_seq(w, 8, DEC_EN & 1'($urandom_range(0, 1)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
